// File: rtl/snitch_ipu_arbiter_if.sv
// Handshake bundle between NumReq accelerator requesters, the arbiter and
// one shared IPU.
//
// Ports (interface signals):
//   req_q*      per-requester request (id, op, three operands, valid/ready)
//   req_p*      per-requester response (data, id, error, valid/ready)
//   ipu_q*      request toward the IPU, id carries {index, requester id}
//   ipu_p*      response from the IPU
//
// Modports:
//   slave   arbiter view
//   master  environment view (requesters plus IPU)
interface snitch_ipu_arbiter_if #(
    parameter int NumReq  = 4,
    parameter int IdWidth = 5
);
    localparam int IdxWidth = $clog2(NumReq);
    localparam int IpuIdW   = IdWidth + IdxWidth;

    logic [NumReq-1:0][IdWidth-1:0] req_qid;
    logic [NumReq-1:0][31:0]        req_qdata_op;
    logic [NumReq-1:0][31:0]        req_qdata_arga;
    logic [NumReq-1:0][31:0]        req_qdata_argb;
    logic [NumReq-1:0][31:0]        req_qdata_argc;
    logic [NumReq-1:0]              req_qvalid;
    logic [NumReq-1:0]              req_qready;
    logic [NumReq-1:0][31:0]        req_pdata;
    logic [NumReq-1:0][IdWidth-1:0] req_pid;
    logic [NumReq-1:0]              req_perror;
    logic [NumReq-1:0]              req_pvalid;
    logic [NumReq-1:0]              req_pready;

    logic [IpuIdW-1:0]              ipu_qid;
    logic [31:0]                    ipu_qdata_op;
    logic [31:0]                    ipu_qdata_arga;
    logic [31:0]                    ipu_qdata_argb;
    logic [31:0]                    ipu_qdata_argc;
    logic                           ipu_qvalid;
    logic                           ipu_qready;
    logic [31:0]                    ipu_pdata;
    logic [IpuIdW-1:0]              ipu_pid;
    logic                           ipu_perror;
    logic                           ipu_pvalid;
    logic                           ipu_pready;

    modport slave (
        input  req_qid, req_qdata_op, req_qdata_arga,
        input  req_qdata_argb, req_qdata_argc, req_qvalid,
        output req_qready,
        output req_pdata, req_pid, req_perror, req_pvalid,
        input  req_pready,
        output ipu_qid, ipu_qdata_op, ipu_qdata_arga,
        output ipu_qdata_argb, ipu_qdata_argc, ipu_qvalid,
        input  ipu_qready,
        input  ipu_pdata, ipu_pid, ipu_perror, ipu_pvalid,
        output ipu_pready
    );

    modport master (
        output req_qid, req_qdata_op, req_qdata_arga,
        output req_qdata_argb, req_qdata_argc, req_qvalid,
        input  req_qready,
        input  req_pdata, req_pid, req_perror, req_pvalid,
        output req_pready,
        input  ipu_qid, ipu_qdata_op, ipu_qdata_arga,
        input  ipu_qdata_argb, ipu_qdata_argc, ipu_qvalid,
        output ipu_qready,
        output ipu_pdata, ipu_pid, ipu_perror, ipu_pvalid,
        input  ipu_pready
    );
endinterface

// File: rtl/snitch_ipu_arbiter.sv
// Round-robin arbiter with grant locking and per-requester credit counters
// sharing one IPU among NumReq requesters.
//
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   bus     request/response bundle (slave modport)
//   busy_o  any requester has operations in flight
module snitch_ipu_arbiter #(
    parameter int NumReq         = 4,
    parameter int IdWidth        = 5,
    parameter int MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    snitch_ipu_arbiter_if.slave  bus,
    output logic                 busy_o
);
    localparam int IdxWidth = $clog2(NumReq);
    localparam int CntWidth = $clog2(MaxOutstanding + 1);

    typedef logic [IdxWidth-1:0] idx_t;
    typedef logic [CntWidth-1:0] cnt_t;

    idx_t                   rr_q;
    logic                   lock_q;
    idx_t                   lock_idx_q;
    cnt_t [NumReq-1:0]      cnt_q;

    logic [NumReq-1:0]      eligible;
    logic                   found;
    idx_t                   winner;
    idx_t                   grant;
    logic                   qhs;
    idx_t                   pidx;
    logic                   pin_range;
    logic                   phs;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            eligible[i] = bus.req_qvalid[i] &&
                          (cnt_q[i] < cnt_t'(MaxOutstanding));
        end
    end

    // First eligible index at or after the pointer, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NumReq; k++) begin
            int j;
            j = (int'(rr_q) + k) % NumReq;
            if (!found && eligible[j]) begin
                found  = 1'b1;
                winner = idx_t'(j);
            end
        end
    end

    // A stalled grant stays with its requester until the IPU accepts it.
    assign grant          = lock_q ? lock_idx_q : winner;
    assign bus.ipu_qvalid = lock_q ? bus.req_qvalid[lock_idx_q] : found;
    assign qhs            = bus.ipu_qvalid & bus.ipu_qready;

    assign bus.ipu_qid        = {grant, bus.req_qid[grant]};
    assign bus.ipu_qdata_op   = bus.req_qdata_op[grant];
    assign bus.ipu_qdata_arga = bus.req_qdata_arga[grant];
    assign bus.ipu_qdata_argb = bus.req_qdata_argb[grant];
    assign bus.ipu_qdata_argc = bus.req_qdata_argc[grant];

    always_comb begin
        bus.req_qready = '0;
        if (bus.ipu_qvalid) begin
            bus.req_qready[grant] = bus.ipu_qready;
        end
    end

    // Responses are steered by the index carried in the upper id bits.
    assign pidx      = bus.ipu_pid[IdWidth +: IdxWidth];
    assign pin_range = int'(pidx) < NumReq;
    assign phs       = bus.ipu_pvalid & bus.ipu_pready & pin_range;

    always_comb begin
        bus.req_pvalid = '0;
        bus.ipu_pready = 1'b1;
        if (pin_range) begin
            bus.req_pvalid[pidx] = bus.ipu_pvalid;
            bus.ipu_pready       = bus.req_pready[pidx];
        end
        for (int i = 0; i < NumReq; i++) begin
            bus.req_pdata[i]  = bus.ipu_pdata;
            bus.req_pid[i]    = bus.ipu_pid[IdWidth-1:0];
            bus.req_perror[i] = bus.ipu_perror;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            if (qhs) begin
                rr_q   <= idx_t'((int'(grant) + 1) % NumReq);
                lock_q <= 1'b0;
            end else if (bus.ipu_qvalid) begin
                lock_q     <= 1'b1;
                lock_idx_q <= grant;
            end
        end
    end

    // Decrement at zero is dropped so stale responses cannot wrap a counter.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumReq; i++) begin
            logic inc;
            logic dec;
            inc = qhs && (grant == idx_t'(i));
            dec = phs && (pidx == idx_t'(i));
            if (!rst_ni) begin
                cnt_q[i] <= '0;
            end else if (inc && !dec) begin
                cnt_q[i] <= cnt_q[i] + cnt_t'(1);
            end else if (dec && !inc && (cnt_q[i] != '0)) begin
                cnt_q[i] <= cnt_q[i] - cnt_t'(1);
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            busy_o = busy_o | (cnt_q[i] != '0);
        end
    end
endmodule

// File: tb/tb_snitch_ipu_arbiter.sv
// Directed bench for snitch_ipu_arbiter with NumReq=4, IdWidth=5,
// MaxOutstanding=2.
module tb_snitch_ipu_arbiter;
    localparam int NumReq  = 4;
    localparam int IdWidth = 5;
    localparam int MaxOut  = 2;

    logic clk;
    logic rst_n;
    logic busy;
    int   n_checks;
    int   n_errors;

    snitch_ipu_arbiter_if #(.NumReq(NumReq), .IdWidth(IdWidth)) bus ();

    snitch_ipu_arbiter #(
        .NumReq(NumReq),
        .IdWidth(IdWidth),
        .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_qvalid = '0;
        bus.req_pready = '0;
        bus.ipu_qready = 1'b0;
        bus.ipu_pvalid = 1'b0;
        bus.ipu_pid    = '0;
        bus.ipu_pdata  = '0;
        bus.ipu_perror = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] qidx();
        return 32'(bus.ipu_qid[IdWidth +: 2]);
    endfunction

    initial begin
        logic [1:0] exp_g [4];
        exp_g[0] = 2'd0; exp_g[1] = 2'd2;
        exp_g[2] = 2'd0; exp_g[3] = 2'd2;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            bus.req_qid[i]        = 5'(i + 10);
            bus.req_qdata_op[i]   = 32'h1000 + 32'(i);
            bus.req_qdata_arga[i] = 32'h2000 + 32'(i);
            bus.req_qdata_argb[i] = 32'h3000 + 32'(i);
            bus.req_qdata_argc[i] = 32'h4000 + 32'(i);
        end
        do_reset();

        // reset state and idle outputs
        check("rst_qvalid", 32'(bus.ipu_qvalid), 0);
        check("rst_qready", 32'(bus.req_qready), 0);
        check("rst_pvalid", 32'(bus.req_pvalid), 0);
        check("rst_busy", 32'(busy), 0);
        bus.req_pready = 4'b0100;
        bus.ipu_pid    = {2'd2, 5'd0};
        #1;
        check("idle_pready2", 32'(bus.ipu_pready), 1);
        bus.ipu_pid = {2'd1, 5'd0};
        #1;
        check("idle_pready1", 32'(bus.ipu_pready), 0);

        // round robin between 0 and 2 until credits run out
        bus.req_pready = '0;
        bus.req_qvalid = 4'b0101;
        bus.ipu_qready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rr_qvalid", 32'(bus.ipu_qvalid), 1);
            check("rr_grant", qidx(), 32'(exp_g[k]));
            check("rr_qid", 32'(bus.ipu_qid),
                  32'({exp_g[k], 5'(exp_g[k] + 10)}));
            check("rr_qready", 32'(bus.req_qready),
                  32'(4'b0001 << exp_g[k]));
            check("rr_op", bus.ipu_qdata_argb, 32'h3000 + 32'(exp_g[k]));
            tick();
        end
        check("rr_exhaust", 32'(bus.ipu_qvalid), 0);
        check("rr_busy", 32'(busy), 1);

        // grant lock on a stalled IPU
        do_reset();
        bus.req_qvalid = 4'b0010;
        #1;
        check("lk_grant0", qidx(), 1);
        tick();
        bus.req_qvalid = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("lk_hold", qidx(), 1);
            check("lk_qready", 32'(bus.req_qready), 0);
            tick();
        end
        bus.ipu_qready = 1'b1;
        #1;
        check("lk_hs_grant", qidx(), 1);
        check("lk_hs_qready", 32'(bus.req_qready), 32'b0010);
        tick();
        bus.req_qvalid = 4'b0001;
        #1;
        check("lk_next", qidx(), 0);
        check("lk_next_v", 32'(bus.ipu_qvalid), 1);

        // credit limit on requester 3
        do_reset();
        bus.req_qvalid = 4'b1000;
        bus.ipu_qready = 1'b1;
        tick();
        tick();
        bus.req_qvalid = 4'b1001;
        #1;
        check("cr_qready", 32'(bus.req_qready), 32'b0001);
        check("cr_grant", qidx(), 0);
        tick();
        bus.req_qvalid = 4'b1000;
        bus.ipu_pvalid = 1'b1;
        bus.ipu_pid    = {2'd3, 5'd4};
        bus.req_pready = 4'b1000;
        #1;
        check("cr_blocked", 32'(bus.ipu_qvalid), 0);
        check("cr_pvalid", 32'(bus.req_pvalid), 32'b1000);
        check("cr_pready", 32'(bus.ipu_pready), 1);
        tick();
        bus.ipu_pvalid = 1'b0;
        #1;
        check("cr_again", 32'(bus.ipu_qvalid), 1);
        check("cr_again_g", qidx(), 3);

        // simultaneous request and response on requester 1
        do_reset();
        bus.req_qvalid = 4'b0010;
        bus.ipu_qready = 1'b1;
        tick();
        bus.ipu_pvalid = 1'b1;
        bus.ipu_pid    = {2'd1, 5'd7};
        bus.ipu_pdata  = 32'hcafe_f00d;
        bus.ipu_perror = 1'b1;
        bus.req_pready = 4'b0010;
        #1;
        check("sm_pvalid", 32'(bus.req_pvalid), 32'b0010);
        check("sm_pid1", 32'(bus.req_pid[1]), 7);
        check("sm_pid3", 32'(bus.req_pid[3]), 7);
        check("sm_pdata2", bus.req_pdata[2], 32'hcafe_f00d);
        check("sm_perr0", 32'(bus.req_perror[0]), 1);
        check("sm_qvalid", 32'(bus.ipu_qvalid), 1);
        tick();
        bus.ipu_pvalid = 1'b0;
        bus.ipu_perror = 1'b0;
        #1;
        check("sm_still_elig", 32'(bus.ipu_qvalid), 1);
        tick();
        check("sm_full", 32'(bus.ipu_qvalid), 0);
        bus.req_qvalid = '0;
        bus.ipu_pvalid = 1'b1;
        bus.ipu_pid    = {2'd1, 5'd0};
        tick();
        tick();
        check("sm_drained", 32'(busy), 0);
        tick();
        check("sm_no_wrap", 32'(busy), 0);

        // response stalled by requester 2
        do_reset();
        bus.req_qvalid = 4'b0100;
        bus.ipu_qready = 1'b1;
        tick();
        bus.req_qvalid = '0;
        bus.ipu_pvalid = 1'b1;
        bus.ipu_pid    = {2'd2, 5'd3};
        bus.ipu_pdata  = 32'h1234_5678;
        bus.req_pready = 4'b1011;
        #1;
        check("st_pready", 32'(bus.ipu_pready), 0);
        check("st_pvalid", 32'(bus.req_pvalid), 32'b0100);
        tick();
        check("st_hold_data", bus.req_pdata[2], 32'h1234_5678);
        check("st_busy", 32'(busy), 1);
        bus.req_pready = 4'b1111;
        tick();
        check("st_done", 32'(busy), 0);

        // reset while locked with credits in use
        do_reset();
        bus.req_qvalid = 4'b0001;
        bus.ipu_qready = 1'b1;
        tick();
        bus.ipu_qready = 1'b0;
        bus.req_qvalid = 4'b0010;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req_qvalid = 4'b0101;
        #1;
        check("mr_busy", 32'(busy), 0);
        check("mr_qvalid", 32'(bus.ipu_qvalid), 1);
        check("mr_grant", qidx(), 0);
        bus.req_qvalid = '0;
        bus.ipu_pvalid = 1'b1;
        bus.ipu_pid    = {2'd0, 5'd1};
        bus.req_pready = 4'b0001;
        #1;
        check("mr_stale_pv", 32'(bus.req_pvalid), 32'b0001);
        check("mr_stale_pr", 32'(bus.ipu_pready), 1);
        tick();
        bus.ipu_pvalid = 1'b0;
        #1;
        check("mr_cnt0", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
